// File: rtl/bnn_xnor_popcount.sv
// Binary-neuron front end: serially XNORs activation/weight bit pairs and accumulates
// the match popcount. Each completed evaluation presents its result with a load/done pulse.
module bnn_xnor_popcount #(
  parameter int N_INPUTS  = 32,
  parameter int THRESHOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       act_bit,
  input  logic       wt_bit,
  input  logic       bit_valid,
  output logic       busy,
  output logic       load,
  output logic [5:0] data,
  output logic       act_out,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [5:0] LAST_IDX = 6'(N_INPUTS - 1);
  localparam logic [5:0] THRESH   = 6'(THRESHOLD);

  state_t     state_r;
  state_t     next_state_s;
  logic [5:0] acc_r;
  logic [5:0] idx_r;
  logic [5:0] acc_next_s;
  logic [5:0] idx_next_s;
  logic       match_s;

  logic       busy_r;
  logic       load_r;
  logic [5:0] data_r;
  logic       act_out_r;
  logic       busy_next_s;
  logic       load_next_s;
  logic [5:0] data_next_s;
  logic       act_out_next_s;

  assign match_s = ~(act_bit ^ wt_bit);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; start outside IDLE is deliberately ignored
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = ACCUM;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCUM: begin
        if (bit_valid && (idx_r == LAST_IDX)) begin
          next_state_s = DONE;
        end else begin
          next_state_s = ACCUM;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Accumulator / pair index next values
  always_comb begin
    acc_next_s = acc_r;
    idx_next_s = idx_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          acc_next_s = 6'd0;
          idx_next_s = 6'd0;
        end else begin
          acc_next_s = acc_r;
          idx_next_s = idx_r;
        end
      end
      ACCUM: begin
        if (bit_valid) begin
          acc_next_s = acc_r + {5'd0, match_s};
          idx_next_s = idx_r + 6'd1;
        end else begin
          acc_next_s = acc_r;
          idx_next_s = idx_r;
        end
      end
      default: begin
        acc_next_s = acc_r;
        idx_next_s = idx_r;
      end
    endcase
  end

  // Accumulator / pair index registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r <= 6'd0;
      idx_r <= 6'd0;
    end else begin
      acc_r <= acc_next_s;
      idx_r <= idx_next_s;
    end
  end

  // Output decode from the next state so every output is a plain flop during that state
  always_comb begin
    busy_next_s    = 1'b0;
    load_next_s    = 1'b0;
    data_next_s    = data_r;
    act_out_next_s = act_out_r;
    case (next_state_s)
      IDLE: begin
        busy_next_s = 1'b0;
        load_next_s = 1'b0;
      end
      ACCUM: begin
        busy_next_s = 1'b1;
        load_next_s = 1'b0;
      end
      DONE: begin
        busy_next_s    = 1'b1;
        load_next_s    = 1'b1;
        data_next_s    = acc_next_s;
        act_out_next_s = (acc_next_s >= THRESH);
      end
      default: begin
        busy_next_s = 1'b0;
        load_next_s = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r    <= 1'b0;
      load_r    <= 1'b0;
      data_r    <= 6'd0;
      act_out_r <= 1'b0;
    end else begin
      busy_r    <= busy_next_s;
      load_r    <= load_next_s;
      data_r    <= data_next_s;
      act_out_r <= act_out_next_s;
    end
  end

  assign busy    = busy_r;
  assign load    = load_r;
  assign done    = load_r;
  assign data    = data_r;
  assign act_out = act_out_r;

endmodule

// File: tb/tb_bnn_xnor_popcount.sv
// Scoreboard bench for bnn_xnor_popcount: stimulus queues expected results, a negedge
// monitor pops and compares them whenever load/done is presented.
module tb_bnn_xnor_popcount;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       act_bit;
  logic       wt_bit;
  logic       bit_valid;
  logic       busy;
  logic       load;
  logic [5:0] data;
  logic       act_out;
  logic       done;

  int checks     = 0;
  int errors     = 0;
  int load_count = 0;

  typedef struct {
    logic [5:0] data;
    logic       act;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic load_prev = 1'b0;

  always #5 clk = ~clk;

  bnn_xnor_popcount #(.N_INPUTS(32), .THRESHOLD(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .act_bit   (act_bit),
    .wt_bit    (wt_bit),
    .bit_valid (bit_valid),
    .busy      (busy),
    .load      (load),
    .data      (data),
    .act_out   (act_out),
    .done      (done)
  );

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: compare every presented result against the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (load || done) begin
        check("done_eq_load", done, load);
        check("load_single_cycle", load_prev, 0);
        check("busy_in_done", busy, 1);
        load_count++;
        if (exp_q.size() == 0) begin
          check("sb_pending", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          check("data", data, mon_e.data);
          check("act_out", act_out, mon_e.act);
        end
      end
      load_prev <= load;
    end else begin
      load_prev <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full evaluation; restart_at>=0 also pulses start mid-run and during DONE
  task automatic run_eval(input logic [31:0] a, input logic [31:0] w, input int max_gap,
                          input int restart_at, input bit idle_noise,
                          input logic [5:0] exp_d, input logic exp_a);
    int cnt_before;
    int timeout;
    cnt_before = load_count;
    if (idle_noise) begin
      bit_valid = 1'b1;
      act_bit   = 1'b1;
      wt_bit    = 1'b1;
      repeat (3) tick();
      bit_valid = 1'b0;
    end
    exp_q.push_back('{data: exp_d, act: exp_a});
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_accum", busy, 1);
    for (int i = 0; i < 32; i++) begin
      if (max_gap > 0) begin
        bit_valid = 1'b0;
        repeat ($urandom_range(0, max_gap)) tick();
      end
      act_bit   = a[i];
      wt_bit    = w[i];
      bit_valid = 1'b1;
      start     = (i == restart_at);
      tick();
    end
    check("load_latency", load, 1);
    start     = (restart_at >= 0);
    bit_valid = (restart_at >= 0);
    tick();
    start     = 1'b0;
    bit_valid = 1'b0;
    check("load_fall", load, 0);
    timeout = 0;
    while (busy && timeout < 20) begin
      tick();
      timeout++;
    end
    check("busy_after_done", busy, 0);
    check("load_pulses", load_count - cnt_before, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    act_bit   = 1'b0;
    wt_bit    = 1'b0;
    bit_valid = 1'b0;
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_load", load, 0);
    check("rst_data", data, 0);
    check("rst_act", act_out, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    tick();

    // all matches
    run_eval(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, -1, 1'b0, 6'd32, 1'b1);
    // threshold boundary: 16 then 15 matches
    run_eval(32'h5555_5555, 32'hFFFF_FFFF, 0, -1, 1'b0, 6'd16, 1'b1);
    run_eval(32'h5555_5554, 32'hFFFF_FFFF, 0, -1, 1'b0, 6'd15, 1'b0);
    // no matches
    run_eval(32'hA5A5_0F0F, 32'h5A5A_F0F0, 0, -1, 1'b0, 6'd0, 1'b0);
    // 20 matches with random gaps
    run_eval(32'h000F_FFFF, 32'hFFFF_FFFF, 5, -1, 1'b0, 6'd20, 1'b1);
    // 24 matches; start ignored mid-run and in DONE, IDLE bit_valid ignored
    run_eval(32'h0000_FFFF, 32'h0000_00FF, 0, 10, 1'b1, 6'd24, 1'b1);

    // abort at pair 17 with async reset
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      act_bit   = 1'b1;
      wt_bit    = 1'b1;
      bit_valid = 1'b1;
      tick();
    end
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_load", load, 0);
    check("abort_data", data, 0);
    check("abort_act", act_out, 0);
    check("abort_done", done, 0);
    bit_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    // fresh evaluation after abort: 29 matches
    run_eval(32'h0000_0007, 32'h0000_0000, 0, -1, 1'b0, 6'd29, 1'b1);

    repeat (3) tick();
    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
